// File: rtl/pipe_pkg.sv
// Shared pipeline definitions.
//   - mem_size encodings (log2 of the access width in bytes)
//   - REG_ZERO: the hard-wired zero register, which never forwards
//   - ctrl_t: control bundle carried from EX into MEM
package pipe_pkg;

   localparam logic [1:0] SZ_BYTE  = 2'd0;
   localparam logic [1:0] SZ_HALF  = 2'd1;
   localparam logic [1:0] SZ_WORD  = 2'd2;
   localparam logic [1:0] SZ_DWORD = 2'd3;

   localparam int REG_ZERO = 0;

   typedef struct packed {
      logic       reg_write;
      logic       mem_reg_dst;
      logic       mem_write;
      logic [1:0] mem_size;
   } ctrl_t;

endpackage

// File: rtl/byte_lane_gen.sv
// byte_lane_gen: combinational byte-lane enable and alignment check.
// Ports:
//   addr      in  low address bits selecting the starting byte lane
//   size      in  log2 of the access width in bytes (pipe_pkg SZ_*)
//   byte_en   out one bit per byte lane touched by the access
//   align_err out access is misaligned or wider than the datapath
// On align_err, byte_en is forced to 0.
module byte_lane_gen
   import pipe_pkg::*;
#(
   parameter int BE_W = 4,
   parameter int AW   = $clog2(BE_W)
) (
   input  logic [AW-1:0]   addr,
   input  logic [1:0]      size,
   output logic [BE_W-1:0] byte_en,
   output logic            align_err
);

   logic [3:0]      n_bytes;
   logic            unsupported;
   logic            misaligned;
   logic [BE_W-1:0] ones;
   logic [BE_W-1:0] mask;

   always_comb begin
      n_bytes     = 4'd1 << size;
      unsupported = int'(size) > AW;
      misaligned  = (4'(addr) & (n_bytes - 4'd1)) != 4'd0;
      ones        = '1;
      // Shifting by the full lane count yields 0, so a full-width access
      // still gets an all-ones mask.
      mask        = ~(ones << n_bytes);
      align_err   = unsupported | misaligned;
      byte_en     = align_err ? '0 : (mask << addr);
   end

endmodule

// File: rtl/ex_mem_stage_reg.sv
// ex_mem_stage_reg: parametrised EX->MEM pipeline register.
// Holds the ALU result, store data, destination and control for one
// instruction, with stall (hold), flush (bubble), a valid bit, registered
// byte-lane enables / alignment error, and combinational forwarding and
// load-use hazard detection from the stage contents.
// Ports:
//   clock, reset          rising-edge clock, synchronous active-high reset
//   stall, flush          hold stage / insert bubble (flush wins)
//   in_valid, *_in        EX stage instruction and its fields
//   valid_out, *_out      registered stage contents
//   byte_en_out           byte lanes of the memory access
//   align_err_out         misaligned or unsupported access
//   fwd_rs/rt_addr        EX-stage source registers to compare against
//   fwd_rs/rt_hit         forward fwd_data to that source
//   fwd_data              equals alu_out
//   load_use_haz          a source matches a pending load; stall EX
// Optional: define EX_MEM_PERF_CNT_EN to add saturating stall_cnt and
// flush_cnt counters (flush takes precedence over stall).
module ex_mem_stage_reg
   import pipe_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int REG_AW = 5,
   parameter int BE_W   = DATA_W/8
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              stall,
   input  logic              flush,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] alu_in,
   input  logic [DATA_W-1:0] rt_in,
   input  logic [REG_AW-1:0] dst_in,
   input  logic              reg_write_in,
   input  logic              mem_reg_dst_in,
   input  logic              mem_write_in,
   input  logic [1:0]        mem_size_in,
   output logic              valid_out,
   output logic [DATA_W-1:0] alu_out,
   output logic [DATA_W-1:0] rt_out,
   output logic [REG_AW-1:0] dst_out,
   output logic              reg_write_out,
   output logic              mem_reg_dst_out,
   output logic              mem_write_out,
   output logic [BE_W-1:0]   byte_en_out,
   output logic              align_err_out,
   input  logic [REG_AW-1:0] fwd_rs_addr,
   input  logic [REG_AW-1:0] fwd_rt_addr,
   output logic              fwd_rs_hit,
   output logic              fwd_rt_hit,
   output logic [DATA_W-1:0] fwd_data,
`ifdef EX_MEM_PERF_CNT_EN
   output logic [31:0]       stall_cnt,
   output logic [31:0]       flush_cnt,
`endif
   output logic              load_use_haz
);

   localparam int AW = $clog2(BE_W);

   ctrl_t           ctrl_in;
   logic [BE_W-1:0] lane_be;
   logic            lane_err;
   logic            is_mem;
   logic            acc_err;
   logic [BE_W-1:0] nxt_be;
   logic            nxt_mw;
   logic            nxt_rw;
   logic            bubble;

   assign ctrl_in = '{reg_write:   reg_write_in,
                      mem_reg_dst: mem_reg_dst_in,
                      mem_write:   mem_write_in,
                      mem_size:    mem_size_in};

   byte_lane_gen #(.BE_W(BE_W)) u_lane (
      .addr      (alu_in[AW-1:0]),
      .size      (ctrl_in.mem_size),
      .byte_en   (lane_be),
      .align_err (lane_err)
   );

   // Only memory instructions report lanes or alignment errors; a bad
   // access suppresses the store and the load's writeback.
   always_comb begin
      is_mem  = ctrl_in.mem_write | ctrl_in.mem_reg_dst;
      acc_err = is_mem & lane_err;
      nxt_be  = (is_mem & ~acc_err) ? lane_be : '0;
      nxt_mw  = ctrl_in.mem_write & ~acc_err;
      nxt_rw  = ctrl_in.reg_write & ~(acc_err & ctrl_in.mem_reg_dst);
   end

   // reset > flush > stall > load; an invalid load is a bubble.
   assign bubble = reset | flush | (~stall & ~in_valid);

   always_ff @(posedge clock) begin
      if (bubble) begin
         valid_out       <= 1'b0;
         alu_out         <= '0;
         rt_out          <= '0;
         dst_out         <= '0;
         reg_write_out   <= 1'b0;
         mem_reg_dst_out <= 1'b0;
         mem_write_out   <= 1'b0;
         byte_en_out     <= '0;
         align_err_out   <= 1'b0;
      end else if (!stall) begin
         valid_out       <= 1'b1;
         alu_out         <= alu_in;
         rt_out          <= rt_in;
         dst_out         <= dst_in;
         reg_write_out   <= nxt_rw;
         mem_reg_dst_out <= ctrl_in.mem_reg_dst;
         mem_write_out   <= nxt_mw;
         byte_en_out     <= nxt_be;
         align_err_out   <= acc_err;
      end
   end

`ifdef EX_MEM_PERF_CNT_EN
   always_ff @(posedge clock) begin
      if (reset) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else if (flush) begin
         if (flush_cnt != '1) flush_cnt <= flush_cnt + 32'd1;
      end else if (stall) begin
         if (stall_cnt != '1) stall_cnt <= stall_cnt + 32'd1;
      end
   end
`endif

   // Forwarding / hazard lookup; register 0 never matches.
   logic dst_live;
   assign dst_live     = valid_out & reg_write_out & (dst_out != REG_AW'(REG_ZERO));
   assign fwd_data     = alu_out;
   assign fwd_rs_hit   = dst_live & ~mem_reg_dst_out & (dst_out == fwd_rs_addr);
   assign fwd_rt_hit   = dst_live & ~mem_reg_dst_out & (dst_out == fwd_rt_addr);
   assign load_use_haz = dst_live & mem_reg_dst_out &
                         ((dst_out == fwd_rs_addr) | (dst_out == fwd_rt_addr));

endmodule

// File: tb/tb_ex_mem_stage_reg.sv
module tb_ex_mem_stage_reg;

   logic clock = 1'b0;
   always #5 clock = ~clock;

   logic        reset, stall, flush, in_valid;
   logic [31:0] alu_in, rt_in;
   logic [63:0] alu64, rt64;
   logic [4:0]  dst_in, fwd_rs_addr, fwd_rt_addr;
   logic        reg_write_in, mem_reg_dst_in, mem_write_in;
   logic [1:0]  mem_size_in;

   logic        valid_out, reg_write_out, mem_reg_dst_out, mem_write_out, align_err_out;
   logic [31:0] alu_out, rt_out, fwd_data;
   logic [4:0]  dst_out;
   logic [3:0]  byte_en_out;
   logic        fwd_rs_hit, fwd_rt_hit, load_use_haz;

   logic        v64, rw64, mrd64, mw64, err64, rsh64, rth64, haz64;
   logic [63:0] alu_o64, rt_o64, fd64;
   logic [4:0]  dst64;
   logic [7:0]  be64;
`ifdef EX_MEM_PERF_CNT_EN
   logic [31:0] stall_cnt, flush_cnt, stall_cnt64, flush_cnt64;
`endif

   ex_mem_stage_reg #(.DATA_W(32)) u32 (
      .clock(clock), .reset(reset), .stall(stall), .flush(flush), .in_valid(in_valid),
      .alu_in(alu_in), .rt_in(rt_in), .dst_in(dst_in), .reg_write_in(reg_write_in),
      .mem_reg_dst_in(mem_reg_dst_in), .mem_write_in(mem_write_in), .mem_size_in(mem_size_in),
      .valid_out(valid_out), .alu_out(alu_out), .rt_out(rt_out), .dst_out(dst_out),
      .reg_write_out(reg_write_out), .mem_reg_dst_out(mem_reg_dst_out),
      .mem_write_out(mem_write_out), .byte_en_out(byte_en_out), .align_err_out(align_err_out),
      .fwd_rs_addr(fwd_rs_addr), .fwd_rt_addr(fwd_rt_addr), .fwd_rs_hit(fwd_rs_hit),
      .fwd_rt_hit(fwd_rt_hit), .fwd_data(fwd_data),
`ifdef EX_MEM_PERF_CNT_EN
      .stall_cnt(stall_cnt), .flush_cnt(flush_cnt),
`endif
      .load_use_haz(load_use_haz));

   ex_mem_stage_reg #(.DATA_W(64)) u64 (
      .clock(clock), .reset(reset), .stall(stall), .flush(flush), .in_valid(in_valid),
      .alu_in(alu64), .rt_in(rt64), .dst_in(dst_in), .reg_write_in(reg_write_in),
      .mem_reg_dst_in(mem_reg_dst_in), .mem_write_in(mem_write_in), .mem_size_in(mem_size_in),
      .valid_out(v64), .alu_out(alu_o64), .rt_out(rt_o64), .dst_out(dst64),
      .reg_write_out(rw64), .mem_reg_dst_out(mrd64),
      .mem_write_out(mw64), .byte_en_out(be64), .align_err_out(err64),
      .fwd_rs_addr(fwd_rs_addr), .fwd_rt_addr(fwd_rt_addr), .fwd_rs_hit(rsh64),
      .fwd_rt_hit(rth64), .fwd_data(fd64),
`ifdef EX_MEM_PERF_CNT_EN
      .stall_cnt(stall_cnt64), .flush_cnt(flush_cnt64),
`endif
      .load_use_haz(haz64));

   typedef struct {
      logic        v;
      logic [31:0] alu, rt;
      logic [4:0]  dst;
      logic        rw, mrd, mw;
      logic [3:0]  be;
      logic        err;
   } exp_t;

   exp_t  sb[$];
   int    checks = 0;
   int    errors = 0;
   string step_tag = "init";

   function automatic exp_t mk(logic v, logic [31:0] alu, rt, logic [4:0] dst,
                               logic rw, mrd, mw, logic [3:0] be, logic err);
      exp_t e;
      e.v = v; e.alu = alu; e.rt = rt; e.dst = dst;
      e.rw = rw; e.mrd = mrd; e.mw = mw; e.be = be; e.err = err;
      return e;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s.%s observed %0h expected %0h", step_tag, tag, obs, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [31:0] alu, rt, input logic [4:0] dst,
                        input logic rw, mrd, mw, input logic [1:0] sz);
      in_valid = v; alu_in = alu; rt_in = rt; dst_in = dst;
      reg_write_in = rw; mem_reg_dst_in = mrd; mem_write_in = mw; mem_size_in = sz;
      alu64 = 64'(alu); rt64 = 64'(rt);
   endtask

   // One clock edge, then compare the stage against the oldest expectation.
   task automatic tick_check();
      exp_t e;
      @(posedge clock);
      #1;
      if (sb.size() == 0) begin
         checks++; errors++;
         $error("FAIL %s.scoreboard observed empty expected entry", step_tag);
      end else begin
         e = sb.pop_front();
         chk("valid", 64'(valid_out), 64'(e.v));
         chk("alu", 64'(alu_out), 64'(e.alu));
         chk("rt", 64'(rt_out), 64'(e.rt));
         chk("dst", 64'(dst_out), 64'(e.dst));
         chk("reg_write", 64'(reg_write_out), 64'(e.rw));
         chk("mem_reg_dst", 64'(mem_reg_dst_out), 64'(e.mrd));
         chk("mem_write", 64'(mem_write_out), 64'(e.mw));
         chk("byte_en", 64'(byte_en_out), 64'(e.be));
         chk("align_err", 64'(align_err_out), 64'(e.err));
      end
   endtask

   exp_t ez, held;

   initial begin
      ez = mk(0, 0, 0, 0, 0, 0, 0, 4'h0, 0);
      reset = 1; stall = 0; flush = 0; fwd_rs_addr = 0; fwd_rt_addr = 0;
      drive(0, 0, 0, 0, 0, 0, 0, 2'd0);

      // 1: reset, single load, reset again
      step_tag = "reset";
      sb.push_back(ez); tick_check();
      chk("fwd_rs_hit", 64'(fwd_rs_hit), 64'd0);
      chk("u64_valid", 64'(v64), 64'd0);
      step_tag = "load";
      reset = 0;
      drive(1, 32'h1000, 32'hAAAA, 5'd8, 1, 0, 0, 2'd2);
      sb.push_back(mk(1, 32'h1000, 32'hAAAA, 5'd8, 1, 0, 0, 4'h0, 0)); tick_check();
      step_tag = "reset2";
      reset = 1;
      sb.push_back(ez); tick_check();
      reset = 0;

      // 2: byte lanes and alignment
      step_tag = "st_byte";
      drive(1, 32'h1003, 32'h55, 5'd0, 0, 0, 1, 2'd0);
      sb.push_back(mk(1, 32'h1003, 32'h55, 0, 0, 0, 1, 4'b1000, 0)); tick_check();
      step_tag = "st_half_mis";
      drive(1, 32'h1001, 32'h66, 5'd0, 0, 0, 1, 2'd1);
      sb.push_back(mk(1, 32'h1001, 32'h66, 0, 0, 0, 0, 4'b0000, 1)); tick_check();
      step_tag = "st_half_hi";
      drive(1, 32'h1002, 32'h77, 5'd0, 0, 0, 1, 2'd1);
      sb.push_back(mk(1, 32'h1002, 32'h77, 0, 0, 0, 1, 4'b1100, 0)); tick_check();
      step_tag = "ld_word";
      drive(1, 32'h2004, 32'h0, 5'd3, 1, 1, 0, 2'd2);
      sb.push_back(mk(1, 32'h2004, 0, 5'd3, 1, 1, 0, 4'b1111, 0)); tick_check();
      step_tag = "ld_half_mis";
      drive(1, 32'h2003, 32'h0, 5'd3, 1, 1, 0, 2'd1);
      sb.push_back(mk(1, 32'h2003, 0, 5'd3, 0, 1, 0, 4'b0000, 1)); tick_check();
      step_tag = "st_dword32";
      drive(1, 32'h0010, 32'h1, 5'd0, 0, 0, 1, 2'd3);
      sb.push_back(mk(1, 32'h10, 32'h1, 0, 0, 0, 0, 4'b0000, 1)); tick_check();
      chk("u64_dword_be", 64'(be64), 64'hFF);
      chk("u64_dword_err", 64'(err64), 64'd0);

      // 3: stall holds, flush beats stall, invalid load is a bubble
      step_tag = "stall";
      held = mk(1, 32'h3000, 32'hBEEF, 5'd9, 1, 0, 0, 4'h0, 0);
      drive(1, 32'h3000, 32'hBEEF, 5'd9, 1, 0, 0, 2'd2);
      sb.push_back(held); tick_check();
      stall = 1;
      for (int i = 0; i < 3; i++) begin
         drive(1, 32'h5000 + 32'(i), 32'h1234, 5'(10 + i), 1, 1, 1, 2'd0);
         sb.push_back(held); tick_check();
      end
      step_tag = "stall_flush";
      flush = 1;
      sb.push_back(ez); tick_check();
      flush = 0; stall = 0;
      step_tag = "bubble";
      drive(1, 32'h3000, 32'hBEEF, 5'd9, 1, 0, 0, 2'd2);
      sb.push_back(held); tick_check();
      drive(0, 32'h6000, 32'h1, 5'd4, 1, 0, 1, 2'd0);
      sb.push_back(ez); tick_check();
      step_tag = "reset_in_stall";
      drive(1, 32'h3000, 32'hBEEF, 5'd9, 1, 0, 0, 2'd2);
      sb.push_back(held); tick_check();
      stall = 1; reset = 1;
      sb.push_back(ez); tick_check();
      stall = 0; reset = 0;

      // 4: forwarding
      step_tag = "fwd";
      drive(1, 32'h4444, 32'h0, 5'd5, 1, 0, 0, 2'd2);
      sb.push_back(mk(1, 32'h4444, 0, 5'd5, 1, 0, 0, 4'h0, 0)); tick_check();
      fwd_rs_addr = 5'd5; fwd_rt_addr = 5'd6; #1;
      chk("fwd_rs_hit", 64'(fwd_rs_hit), 64'd1);
      chk("fwd_rt_hit", 64'(fwd_rt_hit), 64'd0);
      chk("fwd_data", 64'(fwd_data), 64'h4444);
      chk("load_use_haz", 64'(load_use_haz), 64'd0);
      step_tag = "fwd_r0";
      drive(1, 32'h4444, 32'h0, 5'd0, 1, 0, 0, 2'd2);
      fwd_rs_addr = 5'd0;
      sb.push_back(mk(1, 32'h4444, 0, 5'd0, 1, 0, 0, 4'h0, 0)); tick_check();
      chk("fwd_rs_hit", 64'(fwd_rs_hit), 64'd0);

      // 5: load-use hazard
      step_tag = "load_use";
      drive(1, 32'h0100, 32'h0, 5'd7, 1, 1, 0, 2'd2);
      fwd_rs_addr = 5'd1; fwd_rt_addr = 5'd7;
      sb.push_back(mk(1, 32'h100, 0, 5'd7, 1, 1, 0, 4'b1111, 0)); tick_check();
      chk("load_use_haz", 64'(load_use_haz), 64'd1);
      chk("fwd_rt_hit", 64'(fwd_rt_hit), 64'd0);
      chk("u64_haz", 64'(haz64), 64'd1);

      // 6: 64-bit dword access and counters
      step_tag = "dword64";
      drive(1, 32'h0008, 32'h9, 5'd0, 0, 0, 1, 2'd3);
      sb.push_back(mk(1, 32'h8, 32'h9, 0, 0, 0, 0, 4'h0, 1)); tick_check();
      chk("u64_be", 64'(be64), 64'hFF);
      chk("u64_mw", 64'(mw64), 64'd1);
      chk("u64_alu", alu_o64, 64'h8);
      step_tag = "dword64_mis";
      drive(1, 32'h000C, 32'h9, 5'd0, 0, 0, 1, 2'd3);
      sb.push_back(mk(1, 32'hC, 32'h9, 0, 0, 0, 0, 4'h0, 1)); tick_check();
      chk("u64_err", 64'(err64), 64'd1);
      chk("u64_be", 64'(be64), 64'h00);

      step_tag = "counters";
      reset = 1;
      sb.push_back(ez); tick_check();
      reset = 0; stall = 1;
`ifdef EX_MEM_PERF_CNT_EN
      chk("stall_cnt_rst", 64'(stall_cnt), 64'd0);
      chk("flush_cnt_rst", 64'(flush_cnt), 64'd0);
`endif
      for (int i = 0; i < 4; i++) begin
         sb.push_back(ez); tick_check();
      end
      stall = 0; flush = 1;
      sb.push_back(ez); tick_check();
      stall = 1;
      sb.push_back(ez); tick_check();
      stall = 0; flush = 0;
`ifdef EX_MEM_PERF_CNT_EN
      chk("stall_cnt", 64'(stall_cnt), 64'd4);
      chk("flush_cnt", 64'(flush_cnt), 64'd2);
      chk("stall_cnt64", 64'(stall_cnt64), 64'd4);
      chk("flush_cnt64", 64'(flush_cnt64), 64'd2);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
